// File: rtl/dispatch_queue_pkg.sv
// Shared dispatch header: field-width macros, tag encodings and the queue entry record.
// Every dispatch file imports this package and relies on the macros defined here.
//
// Macros:
//   `OPER_T, `ADDR_T, `WORD_T, `REGTAG_T, `REGADDR_T  instruction field types
// Constants (regtag encodings):
//   UNLOCKED    operand value is final
//   ALU_MASTER  waiting on ALU_MASTER result (en_mw0/write_data0)
//   ALU_SALVER  waiting on ALU_SALVER result (en_mw1/write_data1)
//   LOAD_STORE  waiting on LOAD_STORE result (en_mw2/write_data2)
//   BRANCH_SEL  reserved for branch resolution; never touched by the snoop
`ifndef DISPATCH_DEFS_SVH
`define DISPATCH_DEFS_SVH
`define OPER_T    logic [5:0]
`define ADDR_T    logic [31:0]
`define WORD_T    logic [31:0]
`define REGTAG_T  logic [2:0]
`define REGADDR_T logic [4:0]
`endif

package dispatch_queue_pkg;

  localparam `REGTAG_T UNLOCKED   = 3'd0;
  localparam `REGTAG_T ALU_MASTER = 3'd1;
  localparam `REGTAG_T ALU_SALVER = 3'd2;
  localparam `REGTAG_T LOAD_STORE = 3'd3;
  localparam `REGTAG_T BRANCH_SEL = 3'd4;

  typedef struct packed {
    `OPER_T    op;
    `ADDR_T    pc;
    `WORD_T    imm;
    `WORD_T    datax;
    `WORD_T    datay;
    `REGTAG_T  tagx;
    `REGTAG_T  tagy;
    `REGTAG_T  tagw;
    `REGADDR_T addrw;
  } entry_t;

endpackage

// File: rtl/dispatch_snoop.sv
// Single-operand result snoop. A tag waiting on a producer that broadcasts this cycle is
// unlocked and its data replaced by the broadcast value. UNLOCKED and BRANCH_SEL tags pass
// through untouched.
//
// Ports:
//   tag_i, data_i                 operand tag and data before the snoop
//   en_mw0_i..en_mw2_i            broadcast enables (ALU_MASTER, ALU_SALVER, LOAD_STORE)
//   write_data0_i..write_data2_i  broadcast values
//   tag_o, data_o                 operand tag and data after the snoop
module dispatch_snoop
  import dispatch_queue_pkg::*;
(
  input  `REGTAG_T tag_i,
  input  `WORD_T   data_i,
  input  logic     en_mw0_i,
  input  logic     en_mw1_i,
  input  logic     en_mw2_i,
  input  `WORD_T   write_data0_i,
  input  `WORD_T   write_data1_i,
  input  `WORD_T   write_data2_i,
  output `REGTAG_T tag_o,
  output `WORD_T   data_o
);

  always_comb begin
    tag_o  = tag_i;
    data_o = data_i;
    if (tag_i != UNLOCKED && tag_i != BRANCH_SEL) begin
      // Producer tags are distinct, so at most one branch can hit.
      if (en_mw0_i && tag_i == ALU_MASTER) begin
        tag_o  = UNLOCKED;
        data_o = write_data0_i;
      end else if (en_mw1_i && tag_i == ALU_SALVER) begin
        tag_o  = UNLOCKED;
        data_o = write_data1_i;
      end else if (en_mw2_i && tag_i == LOAD_STORE) begin
        tag_o  = UNLOCKED;
        data_o = write_data2_i;
      end
    end
  end

endmodule

// File: rtl/dispatch_queue.sv
// Dispatch queue: circular FIFO between decoder and allocator. Stored and incoming operands
// are snooped against the three result broadcasts every cycle so that entries pick up results
// while they wait.
//
// Optional feature: define DISPATCH_BYPASS_EN to present an instruction pushed into an empty
// queue on the head outputs in the same cycle; if the allocator takes it that cycle it is not
// written to the queue.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   push_en_in + fields      decoder offer (op/pc/imm/datax/datay/tagx/tagy/tagw/addrw)
//   full_out, count_out      occupancy status
//   valid_out + *0_out       head entry to the allocator (all zero when not valid)
//   issue0_in                allocator accepted the head
//   flush_in                 branch redirect, drop every entry
//   en_mw0..2, write_data0..2 result broadcasts (ALU_MASTER, ALU_SALVER, LOAD_STORE)
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_en_in,
  input  `OPER_T                 op_in,
  input  `ADDR_T                 pc_in,
  input  `WORD_T                 imm_in,
  input  `WORD_T                 datax_in,
  input  `WORD_T                 datay_in,
  input  `REGTAG_T               tagx_in,
  input  `REGTAG_T               tagy_in,
  input  `REGTAG_T               tagw_in,
  input  `REGADDR_T              addrw_in,
  output logic                   full_out,
  output logic                   valid_out,
  output `OPER_T                 op0_out,
  output `ADDR_T                 pc0_out,
  output `WORD_T                 imm0_out,
  output `WORD_T                 datax0_out,
  output `WORD_T                 datay0_out,
  output `REGTAG_T               tagx0_out,
  output `REGTAG_T               tagy0_out,
  output `REGTAG_T               tagw0_out,
  output `REGADDR_T              addrw0_out,
  input  logic                   issue0_in,
  input  logic                   flush_in,
  input  logic                   en_mw0,
  input  logic                   en_mw1,
  input  logic                   en_mw2,
  input  `WORD_T                 write_data0,
  input  `WORD_T                 write_data1,
  input  `WORD_T                 write_data2,
  output logic [$clog2(DEPTH):0] count_out
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  entry_t mem_q   [DEPTH];
  entry_t mem_snp [DEPTH];
  entry_t in_raw, in_snp, head_ent, head_vis;

  `REGTAG_T snp_tagx [DEPTH];
  `REGTAG_T snp_tagy [DEPTH];
  `REGTAG_T snp_tagw [DEPTH];
  `WORD_T   snp_datax [DEPTH];
  `WORD_T   snp_datay [DEPTH];
  `WORD_T   unused_wdata [DEPTH];  // tagw carries no data
  `REGTAG_T in_tagx, in_tagy, in_tagw;
  `WORD_T   in_datax, in_datay, unused_in_wdata;

  logic full, valid, do_push, do_pop;

  assign in_raw = '{op: op_in, pc: pc_in, imm: imm_in, datax: datax_in, datay: datay_in,
                    tagx: tagx_in, tagy: tagy_in, tagw: tagw_in, addrw: addrw_in};

  // Snoop on every stored entry
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    dispatch_snoop u_snoop_x (
      .tag_i(mem_q[i].tagx), .data_i(mem_q[i].datax),
      .en_mw0_i(en_mw0), .en_mw1_i(en_mw1), .en_mw2_i(en_mw2),
      .write_data0_i(write_data0), .write_data1_i(write_data1), .write_data2_i(write_data2),
      .tag_o(snp_tagx[i]), .data_o(snp_datax[i])
    );
    dispatch_snoop u_snoop_y (
      .tag_i(mem_q[i].tagy), .data_i(mem_q[i].datay),
      .en_mw0_i(en_mw0), .en_mw1_i(en_mw1), .en_mw2_i(en_mw2),
      .write_data0_i(write_data0), .write_data1_i(write_data1), .write_data2_i(write_data2),
      .tag_o(snp_tagy[i]), .data_o(snp_datay[i])
    );
    dispatch_snoop u_snoop_w (
      .tag_i(mem_q[i].tagw), .data_i('0),
      .en_mw0_i(en_mw0), .en_mw1_i(en_mw1), .en_mw2_i(en_mw2),
      .write_data0_i(write_data0), .write_data1_i(write_data1), .write_data2_i(write_data2),
      .tag_o(snp_tagw[i]), .data_o(unused_wdata[i])
    );
  end

  // Snoop on the incoming instruction
  dispatch_snoop u_snoop_in_x (
    .tag_i(tagx_in), .data_i(datax_in),
    .en_mw0_i(en_mw0), .en_mw1_i(en_mw1), .en_mw2_i(en_mw2),
    .write_data0_i(write_data0), .write_data1_i(write_data1), .write_data2_i(write_data2),
    .tag_o(in_tagx), .data_o(in_datax)
  );
  dispatch_snoop u_snoop_in_y (
    .tag_i(tagy_in), .data_i(datay_in),
    .en_mw0_i(en_mw0), .en_mw1_i(en_mw1), .en_mw2_i(en_mw2),
    .write_data0_i(write_data0), .write_data1_i(write_data1), .write_data2_i(write_data2),
    .tag_o(in_tagy), .data_o(in_datay)
  );
  dispatch_snoop u_snoop_in_w (
    .tag_i(tagw_in), .data_i('0),
    .en_mw0_i(en_mw0), .en_mw1_i(en_mw1), .en_mw2_i(en_mw2),
    .write_data0_i(write_data0), .write_data1_i(write_data1), .write_data2_i(write_data2),
    .tag_o(in_tagw), .data_o(unused_in_wdata)
  );

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_snp[i]       = mem_q[i];
      mem_snp[i].tagx  = snp_tagx[i];
      mem_snp[i].datax = snp_datax[i];
      mem_snp[i].tagy  = snp_tagy[i];
      mem_snp[i].datay = snp_datay[i];
      mem_snp[i].tagw  = snp_tagw[i];
    end
    in_snp       = in_raw;
    in_snp.tagx  = in_tagx;
    in_snp.datax = in_datax;
    in_snp.tagy  = in_tagy;
    in_snp.datay = in_datay;
    in_snp.tagw  = in_tagw;
  end

  // Full is judged on registered state only, so a pop cannot make room for a same-cycle push.
  assign full   = (count_q == CntW'(DEPTH));
  assign do_pop = issue0_in && (count_q != '0);

`ifdef DISPATCH_BYPASS_EN
  logic bypass;
  assign bypass  = (count_q == '0) && push_en_in && !flush_in;
  // A bypassed instruction taken by the allocator never occupies an entry.
  assign do_push = push_en_in && !full && !(bypass && issue0_in);
`else
  assign do_push = push_en_in && !full;
`endif

  always_comb begin
    head_ent = mem_q[head_q];
    valid    = (count_q != '0);
`ifdef DISPATCH_BYPASS_EN
    if (bypass) begin
      head_ent = in_snp;
      valid    = 1'b1;
    end
`endif
    head_vis = valid ? head_ent : '0;
  end

  assign valid_out  = valid;
  assign full_out   = full;
  assign count_out  = count_q;
  assign op0_out    = head_vis.op;
  assign pc0_out    = head_vis.pc;
  assign imm0_out   = head_vis.imm;
  assign datax0_out = head_vis.datax;
  assign datay0_out = head_vis.datay;
  assign tagx0_out  = head_vis.tagx;
  assign tagy0_out  = head_vis.tagy;
  assign tagw0_out  = head_vis.tagw;
  assign addrw0_out = head_vis.addrw;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + 1'b1;
      if (do_pop)  head_d = head_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; every entry is rewritten with its snooped value each cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (tail_q == PtrW'(i))) mem_q[i] <= in_snp;
      else                                 mem_q[i] <= mem_snp[i];
    end
  end

endmodule

// File: tb/tb_dispatch_queue.sv
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    bit          push, issue, flush, en0, en1, en2;
    logic [31:0] pc, wd0, wd1, wd2;
    logic [2:0]  tagx;
  } stim_t;

  typedef struct {
    stim_t       s;
    int          exp_count;
    bit          exp_full;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] pc, imm, dx, dy;
    logic [2:0]  tx, ty, tw;
    logic [4:0]  aw;
  } ment_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        push_en_in, issue0_in, flush_in, en_mw0, en_mw1, en_mw2;
  logic [5:0]  op_in;
  logic [31:0] pc_in, imm_in, datax_in, datay_in, write_data0, write_data1, write_data2;
  logic [2:0]  tagx_in, tagy_in, tagw_in;
  logic [4:0]  addrw_in;
  logic        full_out, valid_out;
  logic [5:0]  op0_out;
  logic [31:0] pc0_out, imm0_out, datax0_out, datay0_out;
  logic [2:0]  tagx0_out, tagy0_out, tagw0_out;
  logic [4:0]  addrw0_out;
  logic [2:0]  count_out;

  int    ncmp = 0;
  int    nerr = 0;
  ment_t sb[$];
  vec_t  vecs [10];

  always #5 clk = ~clk;

  dispatch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push_en_in(push_en_in), .op_in(op_in), .pc_in(pc_in),
    .imm_in(imm_in), .datax_in(datax_in), .datay_in(datay_in), .tagx_in(tagx_in),
    .tagy_in(tagy_in), .tagw_in(tagw_in), .addrw_in(addrw_in), .full_out(full_out),
    .valid_out(valid_out), .op0_out(op0_out), .pc0_out(pc0_out), .imm0_out(imm0_out),
    .datax0_out(datax0_out), .datay0_out(datay0_out), .tagx0_out(tagx0_out),
    .tagy0_out(tagy0_out), .tagw0_out(tagw0_out), .addrw0_out(addrw0_out),
    .issue0_in(issue0_in), .flush_in(flush_in), .en_mw0(en_mw0), .en_mw1(en_mw1),
    .en_mw2(en_mw2), .write_data0(write_data0), .write_data1(write_data1),
    .write_data2(write_data2), .count_out(count_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t st0();
    stim_t s;
    s.push = 0; s.issue = 0; s.flush = 0; s.en0 = 0; s.en1 = 0; s.en2 = 0;
    s.pc = '0; s.wd0 = '0; s.wd1 = '0; s.wd2 = '0; s.tagx = UNLOCKED;
    return s;
  endfunction

  function automatic vec_t mkv(bit push, bit issue, bit flush, logic [31:0] pc,
                               int cnt, bit full, bit valid, logic [31:0] epc);
    vec_t v;
    v.s = st0();
    v.s.push = push; v.s.issue = issue; v.s.flush = flush; v.s.pc = pc;
    v.exp_count = cnt; v.exp_full = full; v.exp_valid = valid; v.exp_pc = epc;
    return v;
  endfunction

  // Instruction fields are derived from pc so every entry is distinguishable.
  function automatic ment_t mk_ent(logic [31:0] pc, logic [2:0] tagx);
    ment_t e;
    e.op = pc[7:2] ^ 6'h15; e.pc = pc; e.imm = pc * 3; e.dx = pc + 1; e.dy = pc + 2;
    e.tx = tagx; e.ty = pc[2] ? BRANCH_SEL : ALU_SALVER; e.tw = LOAD_STORE; e.aw = pc[6:2];
    return e;
  endfunction

  function automatic void snp1(input logic [2:0] t, input logic [31:0] d, input stim_t s,
                               output logic [2:0] to, output logic [31:0] dout);
    to = t; dout = d;
    if (s.en0 && t == ALU_MASTER) begin to = UNLOCKED; dout = s.wd0; end
    if (s.en1 && t == ALU_SALVER) begin to = UNLOCKED; dout = s.wd1; end
    if (s.en2 && t == LOAD_STORE) begin to = UNLOCKED; dout = s.wd2; end
  endfunction

  function automatic ment_t model_snoop(ment_t e, stim_t s);
    ment_t r = e;
    logic [31:0] dummy;
    snp1(e.tx, e.dx, s, r.tx, r.dx);
    snp1(e.ty, e.dy, s, r.ty, r.dy);
    snp1(e.tw, 32'h0, s, r.tw, dummy);
    return r;
  endfunction

  task automatic idle();
    push_en_in = 0; issue0_in = 0; flush_in = 0; en_mw0 = 0; en_mw1 = 0; en_mw2 = 0;
    write_data0 = '0; write_data1 = '0; write_data2 = '0;
    op_in = '0; pc_in = '0; imm_in = '0; datax_in = '0; datay_in = '0;
    tagx_in = '0; tagy_in = '0; tagw_in = '0; addrw_in = '0;
  endtask

  task automatic check_head();
    chk("count", 64'(count_out), 64'(sb.size()));
    chk("full", 64'(full_out), 64'(sb.size() == DEPTH));
    chk("valid", 64'(valid_out), 64'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("head_op", 64'(op0_out), 64'(sb[0].op));
      chk("head_pc", 64'(pc0_out), 64'(sb[0].pc));
      chk("head_imm", 64'(imm0_out), 64'(sb[0].imm));
      chk("head_datax", 64'(datax0_out), 64'(sb[0].dx));
      chk("head_datay", 64'(datay0_out), 64'(sb[0].dy));
      chk("head_tagx", 64'(tagx0_out), 64'(sb[0].tx));
      chk("head_tagy", 64'(tagy0_out), 64'(sb[0].ty));
      chk("head_tagw", 64'(tagw0_out), 64'(sb[0].tw));
      chk("head_addrw", 64'(addrw0_out), 64'(sb[0].aw));
    end else begin
      chk("head_zero", 64'(|{op0_out, pc0_out, imm0_out, datax0_out, datay0_out,
                             tagx0_out, tagy0_out, tagw0_out, addrw0_out}), 64'(0));
    end
  endtask

  // Drive one cycle, advance the model, then check after the edge with inputs idle.
  task automatic step(input stim_t s);
    ment_t raw, inc;
    bit    push_ok, pop_ok;
    raw = mk_ent(s.pc, s.tagx);
    push_en_in = s.push; issue0_in = s.issue; flush_in = s.flush;
    en_mw0 = s.en0; en_mw1 = s.en1; en_mw2 = s.en2;
    write_data0 = s.wd0; write_data1 = s.wd1; write_data2 = s.wd2;
    op_in = raw.op; pc_in = raw.pc; imm_in = raw.imm; datax_in = raw.dx; datay_in = raw.dy;
    tagx_in = raw.tx; tagy_in = raw.ty; tagw_in = raw.tw; addrw_in = raw.aw;
    inc = model_snoop(raw, s);
    foreach (sb[i]) sb[i] = model_snoop(sb[i], s);
    push_ok = s.push && (sb.size() < DEPTH);
    pop_ok  = s.issue && (sb.size() != 0);
    if (s.flush) sb.delete();
    else begin
      if (pop_ok)  void'(sb.pop_front());
      if (push_ok) sb.push_back(inc);
    end
    @(posedge clk);
    #1 idle();
    #1 check_head();
  endtask

  initial begin
    stim_t s;
    idle();
    rst = 1'b0;
    #3;
    chk("rst_count", 64'(count_out), 64'(0));
    chk("rst_valid", 64'(valid_out), 64'(0));
    chk("rst_full", 64'(full_out), 64'(0));
    chk("rst_head_zero", 64'(|{op0_out, pc0_out, datax0_out, tagx0_out, tagw0_out}), 64'(0));
    #10 rst = 1'b1;
    @(posedge clk);
    #2;

    // Fill, overflow, push+issue while full, flush with push, issue while empty
    vecs[0] = mkv(1, 0, 0, 32'h100, 1, 0, 1, 32'h100);
    vecs[1] = mkv(1, 0, 0, 32'h104, 2, 0, 1, 32'h100);
    vecs[2] = mkv(1, 0, 0, 32'h108, 3, 0, 1, 32'h100);
    vecs[3] = mkv(1, 0, 0, 32'h10C, 4, 1, 1, 32'h100);
    vecs[4] = mkv(1, 0, 0, 32'h110, 4, 1, 1, 32'h100);
    vecs[5] = mkv(1, 1, 0, 32'h114, 3, 0, 1, 32'h104);
    vecs[6] = mkv(0, 1, 0, 32'h0,   2, 0, 1, 32'h108);
    vecs[7] = mkv(1, 0, 0, 32'h118, 3, 0, 1, 32'h108);
    vecs[8] = mkv(1, 0, 1, 32'h11C, 0, 0, 0, 32'h0);
    vecs[9] = mkv(0, 1, 0, 32'h0,   0, 0, 0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].s);
      chk($sformatf("vec%0d_count", i), 64'(count_out), 64'(vecs[i].exp_count));
      chk($sformatf("vec%0d_full", i), 64'(full_out), 64'(vecs[i].exp_full));
      chk($sformatf("vec%0d_valid", i), 64'(valid_out), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_pc", i), 64'(pc0_out), 64'(vecs[i].exp_pc));
    end

    // Snoop: stored and incoming ALU_SALVER operands unlocked by one broadcast
    s = st0(); s.push = 1; s.pc = 32'h200; s.tagx = ALU_SALVER;
    step(s);
    chk("snp_pre_tagx", 64'(tagx0_out), 64'(ALU_SALVER));
    s = st0(); s.push = 1; s.pc = 32'h204; s.tagx = ALU_SALVER; s.en1 = 1; s.wd1 = 32'hAB;
    step(s);
    chk("snp_tagx", 64'(tagx0_out), 64'(UNLOCKED));
    chk("snp_datax", 64'(datax0_out), 64'h0000_00AB);
    chk("snp_tagy", 64'(tagy0_out), 64'(UNLOCKED));
    s = st0(); s.issue = 1;
    step(s);
    chk("snp_in_tagx", 64'(tagx0_out), 64'(UNLOCKED));
    chk("snp_in_datax", 64'(datax0_out), 64'h0000_00AB);
    chk("snp_branch_kept", 64'(tagy0_out), 64'(BRANCH_SEL));
    chk("snp_branch_data", 64'(datay0_out), 64'h206);
    step(s);

    // Ten push/pop pairs: pointers wrap, order kept, other broadcasts exercised
    s = st0(); s.push = 1; s.pc = 32'h0; s.tagx = LOAD_STORE;
    step(s);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("wrap%0d_order", k), 64'(pc0_out), 64'(4 * (k - 1)));
      s = st0(); s.issue = 1;
      s.push = (k < 10); s.pc = 32'(4 * k);
      s.tagx = (k % 2 == 1) ? ALU_MASTER : LOAD_STORE;
      s.en0 = (k % 3 == 0); s.wd0 = $urandom;
      s.en2 = (k % 4 == 1); s.wd2 = $urandom;
      step(s);
    end

`ifdef DISPATCH_BYPASS_EN
    // Bypass: instruction taken in the same cycle never occupies an entry
    push_en_in = 1; issue0_in = 1; pc_in = 32'h300; tagx_in = UNLOCKED;
    #1;
    chk("byp_valid", 64'(valid_out), 64'(1));
    chk("byp_pc", 64'(pc0_out), 64'h300);
    @(posedge clk);
    #1 idle();
    #1 check_head();
    chk("byp_count", 64'(count_out), 64'(0));
`endif

    // Reset mid-operation discards all entries
    s = st0(); s.push = 1; s.pc = 32'h400;
    step(s);
    s.pc = 32'h404;
    step(s);
    #1 rst = 1'b0;
    #1;
    chk("midrst_count", 64'(count_out), 64'(0));
    chk("midrst_valid", 64'(valid_out), 64'(0));
    sb.delete();
    #1 rst = 1'b1;
    s = st0(); s.push = 1; s.pc = 32'h500;
    step(s);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
